// File: rtl/spi_master_pkg.sv
// rtl/spi_master_pkg.sv - shared SPI master types, state encodings and slave-select decode.
// Optional feature macro used by this slice: SPI_LSB_FIRST_EN.
package spi_master_pkg;

  localparam int NUM_SS = 4;

  typedef logic [0:NUM_SS-1] ss_t;

  localparam ss_t SS_NONE = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_SHIFT = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  // Bit k of the result is slave k; exactly one bit is driven low.
  function automatic ss_t ss_decode(input logic [1:0] idx);
    ss_t ss;
    ss      = SS_NONE;
    ss[idx] = 1'b0;
    return ss;
  endfunction

endpackage

// File: rtl/spi_master_if.sv
// rtl/spi_master_if.sv - request/response and SPI pin bundle for spi_master.
// SPI_LSB_FIRST_EN adds the lsb_first request bit.
interface spi_master_if #(
  parameter int DATA_W = 8
);
  import spi_master_pkg::*;

  logic              start;
  logic [1:0]        slave_sel;
  logic [DATA_W-1:0] tx_data;
`ifdef SPI_LSB_FIRST_EN
  logic              lsb_first;
`endif
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rx_data;
  logic              sclk;
  logic              mosi;
  logic              miso;
  ss_t               ss_n;

  modport master (
`ifdef SPI_LSB_FIRST_EN
    input  lsb_first,
`endif
    input  start, slave_sel, tx_data, miso,
    output busy, done, rx_data, sclk, mosi, ss_n
  );

  modport slave (
`ifdef SPI_LSB_FIRST_EN
    output lsb_first,
`endif
    output start, slave_sel, tx_data, miso,
    input  busy, done, rx_data, sclk, mosi, ss_n
  );

endinterface

// File: rtl/spi_sclk_gen.sv
// rtl/spi_sclk_gen.sv - CLK_DIV phase counter producing sclk and its rise/fall ticks.
module spi_sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic shift_en,
  output logic tick,
  output logic rise_tick,
  output logic fall_tick,
  output logic sclk
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sclk_q, sclk_d;

  // The counter runs through SETUP/SHIFT/HOLD so every phase lasts CLK_DIV cycles;
  // sclk only toggles while the FSM is shifting.
  always_comb begin
    tick      = en && (cnt_q == '0);
    rise_tick = tick && shift_en && !sclk_q;
    fall_tick = tick && shift_en && sclk_q;
    cnt_d     = cnt_q;
    sclk_d    = sclk_q;
    if (!en) begin
      cnt_d  = CNT_LOAD;
      sclk_d = 1'b0;
    end else begin
      cnt_d = tick ? CNT_LOAD : cnt_q - 1'b1;
      if (tick && shift_en) begin
        sclk_d = ~sclk_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= CNT_LOAD;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk = sclk_q;

endmodule

// File: rtl/spi_master.sv
// rtl/spi_master.sv - mode-0 SPI master, one DATA_W frame per start, 4 active-low selects.
// SPI_LSB_FIRST_EN adds a per-frame lsb_first option; default build is MSB-first only.
module spi_master
  import spi_master_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4
) (
  input logic          clk,
  input logic          rst,
  spi_master_if.master bus
);

  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
  logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  ss_t               ss_n_q, ss_n_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              lsb_q, lsb_d;
  logic              lsb_in;

  logic tick, rise_tick, fall_tick, sclk;

  function automatic logic [DATA_W-1:0] bit_rev(input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W; i++) begin
      r[i] = v[DATA_W-1-i];
    end
    return r;
  endfunction

`ifdef SPI_LSB_FIRST_EN
  assign lsb_in = bus.lsb_first;
`else
  assign lsb_in = 1'b0;
`endif

  spi_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk       (clk),
    .rst       (rst),
    .en        (state_q != S_IDLE),
    .shift_en  (state_q == S_SHIFT),
    .tick      (tick),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick),
    .sclk      (sclk)
  );

  always_comb begin
    state_d   = state_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    rx_data_d = rx_data_q;
    bit_cnt_d = bit_cnt_q;
    ss_n_d    = ss_n_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    lsb_d     = lsb_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          // LSB-first is handled by reversing on the way in and out of the shifters.
          tx_sr_d   = lsb_in ? bit_rev(bus.tx_data) : bus.tx_data;
          lsb_d     = lsb_in;
          bit_cnt_d = '0;
          ss_n_d    = ss_decode(bus.slave_sel);
          busy_d    = 1'b1;
          state_d   = S_SETUP;
        end
      end
      S_SETUP: begin
        if (tick) begin
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (rise_tick) begin
          rx_sr_d = {rx_sr_q[DATA_W-2:0], bus.miso};
        end
        if (fall_tick) begin
          if (bit_cnt_q == LAST_BIT) begin
            state_d = S_HOLD;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            tx_sr_d   = {tx_sr_q[DATA_W-2:0], 1'b0};
          end
        end
      end
      S_HOLD: begin
        if (tick) begin
          rx_data_d = lsb_q ? bit_rev(rx_sr_q) : rx_sr_q;
          ss_n_d    = SS_NONE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      rx_data_q <= '0;
      bit_cnt_q <= '0;
      ss_n_q    <= SS_NONE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      lsb_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      rx_data_q <= rx_data_d;
      bit_cnt_q <= bit_cnt_d;
      ss_n_q    <= ss_n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      lsb_q     <= lsb_d;
    end
  end

  // The shifter MSB is the line; the last fall does not shift, so mosi holds its final bit.
  assign bus.mosi    = tx_sr_q[DATA_W-1];
  assign bus.sclk    = sclk;
  assign bus.ss_n    = ss_n_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rx_data = rx_data_q;

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - directed self-checking bench for spi_master (honours SPI_LSB_FIRST_EN).
module tb_spi_master;
  import spi_master_pkg::*;

  localparam int DATA_W    = 8;
  localparam int CLK_DIV   = 4;
  localparam int FRAME_CYC = 1 + CLK_DIV * (2 * DATA_W + 2);

  logic clk = 1'b0;
  logic rst = 1'b1;

  spi_master_if #(.DATA_W(DATA_W)) bus();

  spi_master #(
    .DATA_W  (DATA_W),
    .CLK_DIV (CLK_DIV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  bit         loop_mode  = 1'b1;
  logic [7:0] slv_sr     = 8'h3C;
  logic [7:0] mosi_log   = 8'h00;
  int         sclk_rises = 0;
  int         done_cnt   = 0;

  // Slave 0 model: mode 0, first bit presented on select, next bit on each sclk fall.
  always @(negedge bus.sclk or posedge bus.ss_n[0]) begin
    if (bus.ss_n[0]) slv_sr <= 8'h3C;
    else             slv_sr <= {slv_sr[6:0], 1'b0};
  end

  always @(posedge bus.sclk) begin
    mosi_log   <= {mosi_log[6:0], bus.mosi};
    sclk_rises <= sclk_rises + 1;
  end

  always @(negedge clk) begin
    if (bus.done) done_cnt <= done_cnt + 1;
  end

  assign bus.miso = loop_mode ? bus.mosi : slv_sr[7];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_frame(input logic [1:0] sel, input logic [7:0] tx, input bit hold);
    @(negedge clk);
    bus.slave_sel = sel;
    bus.tx_data   = tx;
    bus.start     = 1'b1;
    @(negedge clk);
    if (!hold) bus.start = 1'b0;
  endtask

  task automatic wait_done(input ss_t exp_ss, input int cyc0, output int cyc, output bit ss_bad);
    cyc    = cyc0;
    ss_bad = 1'b0;
    while (bus.done !== 1'b1 && cyc < 200) begin
      if (bus.busy && bus.ss_n !== exp_ss) ss_bad = 1'b1;
      if ($countones(~bus.ss_n) > 1) ss_bad = 1'b1;
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cyc;
    int  k;
    int  r0;
    int  d0;
    bit  ss_bad;

    bus.start     = 1'b0;
    bus.slave_sel = 2'd0;
    bus.tx_data   = 8'h00;
`ifdef SPI_LSB_FIRST_EN
    bus.lsb_first = 1'b0;
`endif

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ss_n",    32'(bus.ss_n), 32'(4'b1111));
    chk("rst_sclk",    32'(bus.sclk), 32'd0);
    chk("rst_busy",    32'(bus.busy), 32'd0);
    chk("rst_done",    32'(bus.done), 32'd0);
    chk("rst_rx_data", 32'(bus.rx_data), 32'h00);
    rst = 1'b0;

    // Reset at the 4th sclk rise of a frame aborts it with no done pulse.
    loop_mode = 1'b1;
    r0 = sclk_rises;
    start_frame(2'd1, 8'hFF, 1'b0);
    d0 = done_cnt;
    k  = 0;
    while (sclk_rises - r0 < 4 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("abort_wait", 32'(k < 200), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ss_n",    32'(bus.ss_n), 32'(4'b1111));
    chk("abort_sclk",    32'(bus.sclk), 32'd0);
    chk("abort_busy",    32'(bus.busy), 32'd0);
    chk("abort_rx_data", 32'(bus.rx_data), 32'h00);
    repeat (80) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt), 32'(d0));

    // Loopback, slave 2, 8'hA5.
    r0 = sclk_rises;
    start_frame(2'd2, 8'hA5, 1'b0);
    chk("lb_busy_t1",  32'(bus.busy), 32'd1);
    chk("lb_ss_n_t1",  32'(bus.ss_n), 32'(4'b1101));
    chk("lb_mosi_t1",  32'(bus.mosi), 32'd1);
    chk("lb_rx_hold",  32'(bus.rx_data), 32'h00);
    wait_done(4'b1101, 1, cyc, ss_bad);
    chk("lb_done_cyc", 32'(cyc), 32'(FRAME_CYC));
    chk("lb_ss_frame", 32'(ss_bad), 32'd0);
    chk("lb_rx_data",  32'(bus.rx_data), 32'hA5);
    chk("lb_ss_done",  32'(bus.ss_n), 32'(4'b1111));
    chk("lb_busy_done", 32'(bus.busy), 32'd0);
    chk("lb_sclk_done", 32'(bus.sclk), 32'd0);
    chk("lb_sclk_rises", 32'(sclk_rises - r0), 32'd8);

    // Slave 0 returns 8'h3C while master sends 8'hC3.
    loop_mode = 1'b0;
    start_frame(2'd0, 8'hC3, 1'b0);
    wait_done(4'b0111, 1, cyc, ss_bad);
    chk("sl_done_cyc", 32'(cyc), 32'(FRAME_CYC));
    chk("sl_ss_frame", 32'(ss_bad), 32'd0);
    chk("sl_rx_data",  32'(bus.rx_data), 32'h3C);
    chk("sl_mosi_seq", 32'(mosi_log), 32'hC3);

    // start held high through frame 1; inputs changed mid-frame; back-to-back frame 2.
    loop_mode = 1'b1;
    start_frame(2'd3, 8'h5A, 1'b1);
    repeat (10) @(negedge clk);
    bus.tx_data   = 8'h0F;
    bus.slave_sel = 2'd1;
    wait_done(4'b1110, 11, cyc, ss_bad);
    chk("hold_done_cyc", 32'(cyc), 32'(FRAME_CYC));
    chk("hold_ss_frame", 32'(ss_bad), 32'd0);
    chk("hold_rx_data",  32'(bus.rx_data), 32'h5A);
    chk("hold_ss_gap",   32'(bus.ss_n), 32'(4'b1111));
    @(negedge clk);
    bus.start = 1'b0;
    chk("b2b_busy", 32'(bus.busy), 32'd1);
    chk("b2b_ss_n", 32'(bus.ss_n), 32'(4'b1011));
    wait_done(4'b1011, 1, cyc, ss_bad);
    chk("b2b_done_cyc", 32'(cyc), 32'(FRAME_CYC));
    chk("b2b_rx_data",  32'(bus.rx_data), 32'h0F);

    // Bit order: tx 8'h01 in loopback.
`ifdef SPI_LSB_FIRST_EN
    bus.lsb_first = 1'b1;
`endif
    start_frame(2'd0, 8'h01, 1'b0);
`ifdef SPI_LSB_FIRST_EN
    chk("order_first_mosi", 32'(bus.mosi), 32'd1);
`else
    chk("order_first_mosi", 32'(bus.mosi), 32'd0);
`endif
    wait_done(4'b0111, 1, cyc, ss_bad);
    chk("order_done_cyc", 32'(cyc), 32'(FRAME_CYC));
    chk("order_rx_data",  32'(bus.rx_data), 32'h01);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
